imem_loader: RTL

Boot-time program loader that fills the instruction memory from an incoming byte stream (e.g. UART RX) before the pipeline runs. It assembles little-endian bytes into 32-bit words, drives the instruction memory write port at word-aligned addresses starting at 0x00000000, and holds the CPU in reset while loading. It sits between the serial receiver and the write side of `instruction_memory`; the pipeline keeps the read side.

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader_if.sv | 38 +++
 rtl/imem_loader_byte_packer.sv | 53 +++++
 rtl/imem_loader.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the boot-time instruction memory loader and the
// instruction memory it fills.
//   state_t          : loader FSM state encoding
//   IMEM_BASE        : byte address of the first instruction word
//   WORD_BYTES       : bytes per instruction word
//   IMEM_DEPTH_WORDS : default instruction memory capacity in words
//   next_word_addr() : advance a byte address by one instruction word
// -----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [31:0] IMEM_BASE        = 32'h0000_0000;
    localparam int          WORD_BYTES       = 4;
    localparam int          IMEM_DEPTH_WORDS = 256;

    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader's control, byte-stream and memory-write signals.
//   master : drives load_start/load_words and the byte stream, observes the
//            memory write port and status (serial side / testbench)
//   slave  : the loader itself
// Signals:
//   load_start, load_words        : load request and word count
//   byte_valid, byte_data, byte_ready : byte stream handshake
//   we, waddr, wdata              : instruction memory write port
//   busy, done, err               : status (busy doubles as CPU hold)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 load_start;
    logic [CNT_WIDTH-1:0] load_words;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 byte_ready;
    logic                 we;
    logic [31:0]          waddr;
    logic [31:0]          wdata;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output load_start, load_words, byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata, busy, done, err
    );

    modport slave (
        input  load_start, load_words, byte_valid, byte_data,
        output byte_ready, we, waddr, wdata, busy, done, err
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles four little-endian bytes into a 32-bit word. The first accepted
// byte lands in bits [7:0].
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear_i      : restart at byte 0 (lane contents are left as they are)
//   accept_i     : a byte is being taken this cycle
//   byte_i       : the byte being taken
//   word_o       : current lane contents (registered)
//   idx_o        : index of the next byte lane to fill
//   word_full_o  : this accept completes the word (lane 3 is being written)
// -----------------------------------------------------------------------------
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [1:0]  idx_o,
    output logic        word_full_o
);

    logic [1:0] idx_q;
    logic [7:0] lane_q [4];

    // Index wraps naturally from 3 back to 0 after a full word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= 2'd0;
        end else if (clear_i) begin
            idx_q <= 2'd0;
        end else if (accept_i) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_q[gi] <= 8'h00;
            end else if (accept_i && !clear_i && idx_q == 2'(gi)) begin
                lane_q[gi] <= byte_i;
            end
        end
    end

    assign word_o      = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
    assign idx_o       = idx_q;
    assign word_full_o = accept_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Fills instruction memory from a byte stream at boot. Bytes are packed into
// little-endian words and written at consecutive word addresses starting at
// IMEM_BASE while busy holds the CPU in reset.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset; aborts a load, drops partial words
//   bus  : imem_loader_if slave (load request, byte stream, write port, status)
// Every output on bus is a register or a register slice.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter int CNT_WIDTH   = 16
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] target_q;
    logic [CNT_WIDTH-1:0] word_cnt_q;
    logic [CNT_WIDTH-1:0] word_cnt_d;
    logic [31:0]          waddr_q;
    logic                 byte_ready_q;
    logic                 we_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    logic                 start_accept;
    logic                 byte_accept;
    logic                 word_full;
    logic [31:0]          packed_word;
    logic [1:0]           packed_idx;

    // byte_ready_q is only ever high in RECV, so it alone gates acceptance.
    assign byte_accept  = bus.byte_valid && byte_ready_q;
    assign start_accept = (state_q == ST_IDLE) && bus.load_start;
    assign word_cnt_d   = word_cnt_q + CNT_WIDTH'(1);

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (start_accept),
        .accept_i    (byte_accept),
        .byte_i      (bus.byte_data),
        .word_o      (packed_word),
        .idx_o       (packed_idx),
        .word_full_o (word_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            word_cnt_q   <= '0;
            waddr_q      <= IMEM_BASE;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        target_q   <= CNT_WIDTH'(bus.load_words);
                        word_cnt_q <= '0;
                        waddr_q    <= IMEM_BASE;
                        err_q      <= 1'b0;
                        if (bus.load_words == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (32'(bus.load_words) > DEPTH_U) begin
                            state_q <= ST_ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q      <= ST_RECV;
                            busy_q       <= 1'b1;
                            byte_ready_q <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (word_full) begin
                        state_q      <= ST_WRITE;
                        we_q         <= 1'b1;
                        byte_ready_q <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    word_cnt_q <= word_cnt_d;
                    if (word_cnt_d == target_q) begin
                        // The address is left on the last word so it never
                        // points past the end of memory.
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q      <= ST_RECV;
                        waddr_q      <= next_word_addr(waddr_q);
                        byte_ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_ERROR: begin
                    // err_q stays set until the next accepted start.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    byte_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // The packer index is implied by the FSM flow; it is not needed here.
    logic unused_idx;
    assign unused_idx = ^packed_idx;

    assign bus.byte_ready = byte_ready_q;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = packed_word;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule
